// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional feature macro used by this slice: FETCH_PERF_EN (performance counters).
package fetch_pkg;

    // Fetch FSM: FETCH drives a request, HOLD parks a word while decode is stalled.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    // Bubble encoding placed in IF/ID: addi x0,x0,0.
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Sequential instruction stride in bytes.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Every PC load is word aligned; low two bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running, wrapping event counters for the fetch stage.
// Only instantiated when FETCH_PERF_EN is defined.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetched_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stall_q,   stall_d;

    // Next-count computation; both counters wrap modulo 2^32.
    always_comb begin
        fetched_d = fetched_q;
        stall_d   = stall_q;
        if (fetched_inc) fetched_d = fetched_q + 32'd1;
        if (stall_inc)   stall_d   = stall_q + 32'd1;
    end

    // Counter registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// request port and holds the IF/ID pipeline register feeding decode.
// Optional feature macro: FETCH_PERF_EN adds perf_fetched / perf_stall.
//
// Memory handshake: imem_req is a registered request; imem_addr is held
// stable while imem_req=1 and imem_ready=0. A transfer completes in a cycle
// where imem_req=1 and imem_ready=1, and imem_rdata is only sampled then.
// The memory must tolerate imem_req dropping before ready (reset abandons
// an outstanding request).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         Select_PC,
    input  logic [31:0]  dir_salto,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instruccion,
    output logic [31:0]  PCmas4,
    output logic         valid_D,
`ifdef FETCH_PERF_EN
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall,
`endif
    output fetch_state_e dbg_state
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic         kill_q, kill_d;       // in-flight word belongs to a squashed path
    logic [31:0]  target_q, target_d;   // redirect target waiting for completion
    logic [31:0]  buf_q, buf_d;         // word parked during HOLD
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcmas4_q, pcmas4_d;
    logic         valid_q, valid_d;

    logic [31:0]  pc_plus4;
    logic         redirect;

    // A branch only counts when decode really holds an instruction and advances.
    assign redirect = Select_PC & valid_q & ~stall;
    assign pc_plus4 = pc_q + PC_STEP;

    // Next-state logic for the PC, the fetch FSM and the IF/ID register.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        kill_d   = kill_q;
        target_d = target_q;
        buf_d    = buf_q;
        instr_d  = instr_q;
        pcmas4_d = pcmas4_q;
        valid_d  = valid_q;

        case (state_q)
            FETCH: begin
                if (!req_q) begin
                    // First cycle out of reset: start requesting.
                    req_d = 1'b1;
                end else if (imem_ready) begin
                    if (redirect) begin
                        // Word arriving now is on the wrong path.
                        pc_d    = align_pc(dir_salto);
                        kill_d  = 1'b0;
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else if (kill_q) begin
                        // Squashed word completes; resume at the saved target.
                        pc_d   = target_q;
                        kill_d = 1'b0;
                        if (!stall) begin
                            instr_d = NOP_INSTR;
                            valid_d = 1'b0;
                        end
                    end else if (stall) begin
                        // Decode busy: park the word and stop requesting.
                        buf_d   = imem_rdata;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        instr_d  = imem_rdata;
                        pcmas4_d = pc_plus4;
                        valid_d  = 1'b1;
                        pc_d     = pc_plus4;
                    end
                end else begin
                    if (redirect) begin
                        // Cannot cancel the pending request; mark it for discard.
                        kill_d   = 1'b1;
                        target_d = align_pc(dir_salto);
                        instr_d  = NOP_INSTR;
                        valid_d  = 1'b0;
                    end else if (!stall) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    if (redirect) begin
                        pc_d    = align_pc(dir_salto);
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else begin
                        instr_d  = buf_q;
                        pcmas4_d = pc_plus4;
                        valid_d  = 1'b1;
                        pc_d     = pc_plus4;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            pc_q     <= align_pc(RESET_PC);
            req_q    <= 1'b0;
            kill_q   <= 1'b0;
            target_q <= 32'd0;
            buf_q    <= 32'd0;
            instr_q  <= NOP_INSTR;
            pcmas4_q <= 32'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            kill_q   <= kill_d;
            target_q <= target_d;
            buf_q    <= buf_d;
            instr_q  <= instr_d;
            pcmas4_q <= pcmas4_d;
            valid_q  <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instruccion = instr_q;
    assign PCmas4      = pcmas4_q;
    assign valid_D     = valid_q;
    assign dbg_state   = state_q;

`ifdef FETCH_PERF_EN
    logic word_loaded;
    logic stall_event;

    // A real word enters IF/ID either straight from memory or from the HOLD buffer.
    assign word_loaded = (state_q == FETCH)
                       ? (req_q & imem_ready & ~redirect & ~kill_q & ~stall)
                       : (~stall & ~redirect);
    assign stall_event = stall | (req_q & ~imem_ready);

    fetch_perf_cnt u_perf (
        .clk          (clk),
        .rst_n        (reset),
        .fetched_inc  (word_loaded),
        .stall_inc    (stall_event),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
    );
`endif

endmodule
